mem_data_arbiter: RTL

//  Shares the single-port data memory (16-bit words, write on posedge, registered read,
//  1-cycle latency) between two requesters: port 0 = pipeline MEM stage, port 1 =

---
 rtl/mem_data_arbiter_pkg.sv | 34 +++
 rtl/mem_data_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_data_arbiter_pkg.sv
// ============================================================================
// Module : mem_data_arbiter_pkg
// Brief  : State encodings, port IDs and winner-select helper for the
//          data-memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_data_arbiter_pkg;

    typedef enum logic [1:0] {
        S_RR    = 2'd0,
        S_LOCK0 = 2'd1,
        S_LOCK1 = 2'd2
    } arb_state_e;

    localparam logic c_PORT_CPU = 1'b0;
    localparam logic c_PORT_DBG = 1'b1;

    // On a conflict the port that was not served last wins.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        if (req1) begin
            return c_PORT_DBG;
        end
        return c_PORT_CPU;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_data_arbiter.sv
// ============================================================================
// Module : mem_data_arbiter
// Brief  : Round-robin arbiter with timed bus lock sharing a single-port
//          data memory between the pipeline MEM stage and the debug loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_data_arbiter
    import mem_data_arbiter_pkg::*;
#(
    parameter int p_WORD_LEN = 16,
    parameter int p_ADDR_LEN = 10,
    parameter int p_LOCK_MAX = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic                  i_lock0,
    input  logic                  i_we0,
    input  logic [p_ADDR_LEN-1:0] i_addr0,
    input  logic [p_WORD_LEN-1:0] i_wdata0,
    input  logic                  i_req1,
    input  logic                  i_lock1,
    input  logic                  i_we1,
    input  logic [p_ADDR_LEN-1:0] i_addr1,
    input  logic [p_WORD_LEN-1:0] i_wdata1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [p_WORD_LEN-1:0] o_rdata0,
    output logic [p_WORD_LEN-1:0] o_rdata1,
    output logic                  o_mem_wr_en,
    output logic [p_ADDR_LEN-1:0] o_mem_addr,
    output logic [p_WORD_LEN-1:0] o_mem_wr_data,
    input  logic [p_WORD_LEN-1:0] i_mem_rd_data
);

    localparam int                 c_CNT_W   = $clog2(p_LOCK_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(p_LOCK_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    arb_state_e         r_state_q, w_state_d;
    logic               r_last_q, w_last_d;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic               r_rvalid0_q, r_rvalid1_q;
    logic               w_gnt0, w_gnt1;
    logic               w_win, w_win_lock;
    logic [c_CNT_W-1:0] w_cnt_inc;

    always_comb begin
        w_state_d  = r_state_q;
        w_last_d   = r_last_q;
        w_cnt_d    = r_cnt_q;
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_win      = pick_winner(i_req0, i_req1, r_last_q);
        w_win_lock = w_win ? i_lock1 : i_lock0;
        w_cnt_inc  = (r_cnt_q == c_CNT_MAX) ? r_cnt_q : r_cnt_q + c_CNT_ONE;

        case (r_state_q)
            S_RR: begin
                if (i_req0 || i_req1) begin
                    w_gnt0   = (w_win == c_PORT_CPU);
                    w_gnt1   = (w_win == c_PORT_DBG);
                    w_last_d = w_win;
                    // The locking grant itself is the first counted cycle.
                    if (w_win_lock && (c_CNT_MAX != c_CNT_ONE)) begin
                        w_state_d = w_win ? S_LOCK1 : S_LOCK0;
                        w_cnt_d   = c_CNT_ONE;
                    end
                end
            end
            S_LOCK0: begin
                w_gnt0 = i_req0;
                if (i_req0) begin
                    w_last_d = c_PORT_CPU;
                    w_cnt_d  = w_cnt_inc;
                end
                if (!i_lock0 || (i_req0 && (w_cnt_inc == c_CNT_MAX))) begin
                    w_state_d = S_RR;
                    w_cnt_d   = '0;
                end
            end
            S_LOCK1: begin
                w_gnt1 = i_req1;
                if (i_req1) begin
                    w_last_d = c_PORT_DBG;
                    w_cnt_d  = w_cnt_inc;
                end
                if (!i_lock1 || (i_req1 && (w_cnt_inc == c_CNT_MAX))) begin
                    w_state_d = S_RR;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = S_RR;
                w_cnt_d   = '0;
            end
        endcase

        if (i_rst) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q   <= S_RR;
            r_last_q    <= c_PORT_DBG;
            r_cnt_q     <= '0;
            r_rvalid0_q <= 1'b0;
            r_rvalid1_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_last_q    <= w_last_d;
            r_cnt_q     <= w_cnt_d;
            r_rvalid0_q <= w_gnt0 & ~i_we0;
            r_rvalid1_q <= w_gnt1 & ~i_we1;
        end
    end

    assign o_gnt0        = w_gnt0;
    assign o_gnt1        = w_gnt1;
    // A response in flight when reset arrives is suppressed immediately.
    assign o_rvalid0     = r_rvalid0_q & ~i_rst;
    assign o_rvalid1     = r_rvalid1_q & ~i_rst;
    assign o_rdata0      = i_mem_rd_data;
    assign o_rdata1      = i_mem_rd_data;
    assign o_mem_wr_en   = (w_gnt0 & i_we0) | (w_gnt1 & i_we1);
    assign o_mem_addr    = w_gnt1 ? i_addr1  : i_addr0;
    assign o_mem_wr_data = w_gnt1 ? i_wdata1 : i_wdata0;

endmodule

`default_nettype wire
